// File: rtl/ein_pkg.sv
// Shared definitions for the EIN transmit engine.
// The build macro EIN_TX_PARITY_EN adds an odd-parity slot after each byte.
package ein_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    EMO_UP  = 4'd1,
    FETCH   = 4'd2,
    SET_D   = 4'd3,
    CLK_HI  = 4'd4,
    CLK_LO  = 4'd5,
    END_EDI = 4'd6,
    HOLD    = 4'd7,
    END_EMO = 4'd8
  } ein_state_t;

`ifdef EIN_TX_PARITY_EN
  localparam int unsigned EIN_BITS_PER_BYTE = 9;
`else
  localparam int unsigned EIN_BITS_PER_BYTE = 8;
`endif

  // Counter spans 0..EIN_BITS_PER_BYTE-1.
  localparam int unsigned EIN_BITCNT_W = $clog2(EIN_BITS_PER_BYTE);

`ifdef EIN_TX_PARITY_EN
  // Odd parity: total count of ones over byte plus parity bit is odd.
  function automatic logic ein_odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction
`endif

endpackage

// File: rtl/ein_tick_gen.sv
// Protocol-step prescaler: one-cycle tick every CLK_DIV clocks while run=1.
module ein_tick_gen #(
  parameter int unsigned CLK_DIV = 4000,
  parameter int unsigned CNT_W   = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Free-running modulo-CLK_DIV counter, parked at zero while not running.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/ein_tx_encoder.sv
// EIN transmit engine: pops payload bytes and serialises them MSB-first on
// the EMO (envelope), EDI (data) and ECI (clock) pads, one pad edge per tick.
// Build option: define EIN_TX_PARITY_EN to append an odd-parity bit per byte.
module ein_tx_encoder
  import ein_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4000,
  parameter int unsigned CNT_W   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_empty,
  output logic       in_re,
  input  logic       start_tx,
  input  logic       fragment,
  output logic       emo_out,
  output logic       edi_out,
  output logic       eci_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned SHREG_W = EIN_BITS_PER_BYTE;

  ein_state_t               state;
  logic [SHREG_W-1:0]       shreg;
  logic [EIN_BITCNT_W-1:0]  bitcnt;
  logic                     run;
  logic                     tick;

  // Prescaler runs only in tick-paced states so every slot starts a full period.
  assign run = (state != IDLE) && (state != FETCH) && (state != HOLD);

  ein_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  // Frame sequencer; pads are updated on entry to each state.
  // in_re is raised on entry to FETCH so the pop and the data capture share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      in_re   <= 1'b0;
      emo_out <= 1'b0;
      edi_out <= 1'b0;
      eci_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      in_re <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_tx) begin
            state   <= EMO_UP;
            emo_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        EMO_UP: begin
          if (tick) begin
            state <= FETCH;
            in_re <= !in_empty;
          end
        end
        FETCH: begin
          if (in_re) begin
`ifdef EIN_TX_PARITY_EN
            shreg <= {in_data, ein_odd_parity(in_data)};
`else
            shreg <= in_data;
`endif
            bitcnt  <= EIN_BITCNT_W'(EIN_BITS_PER_BYTE - 1);
            edi_out <= in_data[7];
            state   <= SET_D;
          end else begin
            edi_out <= 1'b0;
            state   <= END_EDI;
          end
        end
        SET_D: begin
          if (tick) begin
            eci_out <= 1'b1;
            state   <= CLK_HI;
          end
        end
        CLK_HI: begin
          if (tick) begin
            eci_out <= 1'b0;
            state   <= CLK_LO;
          end
        end
        CLK_LO: begin
          if (tick) begin
            shreg  <= shreg << 1;
            bitcnt <= bitcnt - EIN_BITCNT_W'(1);
            if (bitcnt == '0) begin
              state <= FETCH;
              in_re <= !in_empty;
            end else begin
              edi_out <= shreg[SHREG_W-2];
              state   <= SET_D;
            end
          end
        end
        END_EDI: begin
          if (tick) begin
            if (fragment) begin
              state <= HOLD;
            end else begin
              emo_out <= 1'b0;
              state   <= END_EMO;
            end
          end
        end
        HOLD: begin
          if (start_tx) begin
            state <= FETCH;
            in_re <= !in_empty;
          end
        end
        END_EMO: begin
          if (tick) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          emo_out <= 1'b0;
          edi_out <= 1'b0;
          eci_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ein_tx_encoder.sv
// Scoreboard bench for ein_tx_encoder: a driver queues expected EDI bits and
// EMO envelope lengths per frame; a negedge monitor compares pad activity.
module tb_ein_tx_encoder;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CNT_W   = 4;
`ifdef EIN_TX_PARITY_EN
  localparam int BITS = 9;
`else
  localparam int BITS = 8;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_empty;
  logic       in_re;
  logic       start_tx;
  logic       fragment;
  logic       emo_out;
  logic       edi_out;
  logic       eci_out;
  logic       busy;
  logic       done;

  ein_tx_encoder #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_empty (in_empty),
    .in_re    (in_re),
    .start_tx (start_tx),
    .fragment (fragment),
    .emo_out  (emo_out),
    .edi_out  (edi_out),
    .eci_out  (eci_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit         exp_bits_q[$];
  int         exp_emo_q[$];
  logic [7:0] fifo_q[$];

  int pops = 0;
  int done_cnt = 0;
  int emo_rises = 0;
  int eci_rises = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  function automatic void drive_fifo();
    in_empty = (fifo_q.size() == 0);
    in_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  // Frame buffer model: a pop seen at a posedge takes effect at the next negedge.
  initial begin
    bit seen;
    forever begin
      @(posedge clk);
      seen = (in_re === 1'b1);
      @(negedge clk);
      if (seen && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pops++;
      end
      drive_fifo();
    end
  end

  // Monitor: compares pad edges against the scoreboard queues.
  initial begin
    logic prev_emo = 1'b0;
    logic prev_eci = 1'b0;
    logic rise_edi = 1'b0;
    int   emo_rise_cyc = 0;
    int   emo_fall_cyc = 0;
    int   eci_rise_cyc = 0;
    bit   first_eci = 1'b0;
    bit   done_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        first_eci    = 1'b0;
        done_pending = 1'b0;
      end else begin
        if (emo_out && !prev_emo) begin
          emo_rises++;
          emo_rise_cyc = cyc;
          first_eci    = 1'b1;
        end
        if (!emo_out && prev_emo) begin
          check("edi_low_at_emo_fall", 32'(edi_out), 32'(0));
          check("eci_low_at_emo_fall", 32'(eci_out), 32'(0));
          if (exp_emo_q.size() == 0) begin
            fail_evt("emo_fall_unexpected");
          end else begin
            int e;
            e = exp_emo_q.pop_front();
            if (e >= 0) check("emo_high_cycles", 32'(cyc - emo_rise_cyc), 32'(e));
          end
          emo_fall_cyc = cyc;
          done_pending = 1'b1;
        end
        if (eci_out && !prev_eci) begin
          eci_rises++;
          if (first_eci) begin
            check("emo_to_first_eci", 32'(cyc - emo_rise_cyc), 32'(2 * CLK_DIV + 1));
            first_eci = 1'b0;
          end
          check("emo_high_at_eci", 32'(emo_out), 32'(1));
          if (exp_bits_q.size() == 0) begin
            fail_evt("eci_unexpected");
          end else begin
            bit b;
            b = exp_bits_q.pop_front();
            check("edi_bit", 32'(edi_out), 32'(b));
          end
          eci_rise_cyc = cyc;
          rise_edi     = edi_out;
        end
        if (!eci_out && prev_eci) begin
          check("eci_high_cycles", 32'(cyc - eci_rise_cyc), 32'(CLK_DIV));
          check("edi_stable_eci_high", 32'(edi_out), 32'(rise_edi));
        end
        if (done) begin
          done_cnt++;
          if (done_pending) begin
            check("emo_fall_to_done", 32'(cyc - emo_fall_cyc), 32'(CLK_DIV));
            check("busy_low_at_done", 32'(busy), 32'(0));
            done_pending = 1'b0;
          end else begin
            fail_evt("done_unexpected");
          end
        end
        if (in_re) check("in_re_while_empty", 32'(in_empty), 32'(0));
      end
      prev_emo = emo_out;
      prev_eci = eci_out;
    end
  end

  int exp_pops  = 0;
  int exp_rises = 0;

  // Queue bytes into the buffer and their expected EDI bits, MSB first.
  task automatic load_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      fifo_q.push_back(bytes[i]);
      for (int k = 7; k >= 0; k--) exp_bits_q.push_back(bytes[i][k]);
      if (BITS == 9) exp_bits_q.push_back(~(^bytes[i]));
    end
    exp_pops += bytes.size();
    drive_fifo();
  endtask

  task automatic pulse_start();
    start_tx = 1'b1;
    @(negedge clk);
    start_tx = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), 32'(1));
  endtask

  function automatic int frame_budget(input int n);
    return (3 * BITS * n + 4) * CLK_DIV + n + 20;
  endfunction

  task automatic end_checks();
    check("emo_rises", 32'(emo_rises), 32'(exp_rises));
    check("pops", 32'(pops), 32'(exp_pops));
    check("bits_left", 32'(exp_bits_q.size()), 32'(0));
    check("busy_idle", 32'(busy), 32'(0));
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    int n;
    n = bytes.size();
    exp_emo_q.push_back(CLK_DIV * (2 + 3 * BITS * n) + n + 1);
    exp_rises++;
    load_bytes(bytes);
    pulse_start();
    wait_done(frame_budget(n));
    end_checks();
    repeat (3) @(negedge clk);
  endtask

  task automatic send_fragmented(input logic [7:0] seg1[$], input logic [7:0] seg2[$]);
    int d0;
    int k;
    exp_emo_q.push_back(-1);
    exp_rises++;
    fragment = 1'b1;
    load_bytes(seg1);
    pulse_start();
    k = 0;
    while (exp_bits_q.size() != 0 && k < frame_budget(seg1.size())) begin
      @(negedge clk);
      k++;
    end
    d0 = done_cnt;
    repeat (4 * CLK_DIV + 4) @(negedge clk);
    check("hold_emo", 32'(emo_out), 32'(1));
    check("hold_busy", 32'(busy), 32'(1));
    check("hold_eci", 32'(eci_out), 32'(0));
    check("hold_no_done", 32'(done_cnt - d0), 32'(0));
    fragment = 1'b0;
    load_bytes(seg2);
    pulse_start();
    wait_done(frame_budget(seg2.size()));
    end_checks();
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid_frame(input logic [7:0] b);
    logic [7:0] q[$];
    int base;
    int k;
    q.push_back(b);
    exp_emo_q.push_back(-1);
    exp_rises++;
    base = eci_rises;
    load_bytes(q);
    pulse_start();
    k = 0;
    while (eci_rises < base + 5 && k < frame_budget(1)) begin
      @(negedge clk);
      k++;
    end
    check("reached_bit3", 32'(eci_rises - base), 32'(5));
    reset = 1'b1;
    @(negedge clk);
    check("rst_emo", 32'(emo_out), 32'(0));
    check("rst_edi", 32'(edi_out), 32'(0));
    check("rst_eci", 32'(eci_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_in_re", 32'(in_re), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    exp_bits_q.delete();
    exp_emo_q.delete();
    fifo_q.delete();
    drive_fifo();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] q2[$];
    reset    = 1'b1;
    start_tx = 1'b0;
    fragment = 1'b0;
    drive_fifo();
    repeat (3) @(negedge clk);
    check("reset_emo", 32'(emo_out), 32'(0));
    check("reset_edi", 32'(edi_out), 32'(0));
    check("reset_eci", 32'(eci_out), 32'(0));
    check("reset_in_re", 32'(in_re), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    q = '{8'hA5};
    send_frame(q);
    q = '{8'h00, 8'hFF};
    send_frame(q);
    q.delete();
    send_frame(q);
    check("empty_frame_no_eci", 32'(eci_rises), 32'(3 * BITS));

    q  = '{8'h3C};
    q2 = '{8'hC3};
    send_fragmented(q, q2);

    reset_mid_frame(8'h5A);
    q = '{8'h96};
    send_frame(q);

    q = '{8'h07, 8'h03};
    send_frame(q);

    for (int f = 0; f < 5; f++) begin
      int n;
      q.delete();
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      send_frame(q);
    end

    check("emo_queue_left", 32'(exp_emo_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
